// File: rtl/tile_rd_pkg.sv
// Shared definitions for the tile read sequencer: FSM states, RAM geometry
// defaults and the row bounds helper.
package tile_rd_pkg;

  localparam int unsigned LEN_DEFAULT = 1024;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_PORTS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // A row starting at base fits when all four consecutive words lie below len.
  function automatic logic row_fits(input logic [31:0] base, input int unsigned len);
    return base <= 32'(len - NUM_PORTS);
  endfunction

endpackage

// File: rtl/rd_out_stage.sv
// Single-entry output register with valid/ready handshake carrying one
// 128-bit row plus its last flag.
module rd_out_stage
  import tile_rd_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_PORTS * DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  // The register may take a new beat when empty or when its current beat leaves this cycle.
  assign can_load_o = !valid_q || ready_i;

  // Load a new beat when allowed; otherwise drop valid once the held beat is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i && can_load_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/tile_read_sequencer.sv
// Tile read sequencer: walks num_rows rows of a four-port RAM starting at
// base_addr with a fixed row stride, presenting each row as one 128-bit beat.
module tile_read_sequencer
  import tile_rd_pkg::*;
#(
  parameter int unsigned LEN   = LEN_DEFAULT,
  parameter int unsigned ROW_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                base_addr,
  input  logic [31:0]                row_stride,
  input  logic [ROW_W-1:0]           num_rows,
  output logic [31:0]                ram_addr0,
  output logic [31:0]                ram_addr1,
  output logic [31:0]                ram_addr2,
  output logic [31:0]                ram_addr3,
  input  logic [DATA_W-1:0]          ram_q0,
  input  logic [DATA_W-1:0]          ram_q1,
  input  logic [DATA_W-1:0]          ram_q2,
  input  logic [DATA_W-1:0]          ram_q3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned OUT_W = NUM_PORTS * DATA_W;

  state_e           state_q, state_d;
  logic [31:0]      row_base_q, row_base_d;
  logic [31:0]      stride_q;
  logic [ROW_W-1:0] num_rows_q;
  logic [ROW_W-1:0] r_q, r_d;
  logic             err_q, err_d;
  logic             done_q;
  logic [31:0]      addr_q [NUM_PORTS];

  logic             accept_start;
  logic             bound_err;
  logic             capture;
  logic             last_row;
  logic             can_load;

  assign last_row = (r_q == num_rows_q - ROW_W'(1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (bound_err || (capture && last_row)) state_d = ST_DRAIN;
      ST_DRAIN: if (!out_valid || out_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    accept_start = (state_q == ST_IDLE) && start;
    bound_err    = (state_q == ST_RUN) && !row_fits(row_base_q, LEN);
    capture      = (state_q == ST_RUN) && !bound_err && can_load;
  end

  // Row pointer, row counter and sticky error next values.
  always_comb begin
    row_base_d = row_base_q;
    r_d        = r_q;
    err_d      = err_q;
    if (accept_start) begin
      row_base_d = base_addr;
      r_d        = '0;
      err_d      = 1'b0;
    end else if (bound_err) begin
      err_d = 1'b1;
    end else if (capture) begin
      row_base_d = row_base_q + stride_q;
      r_d        = r_q + ROW_W'(1);
    end
  end

  // Datapath registers; RAM addresses are loaded from the next row base so they
  // always equal row_base + K while still clearing to zero on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_base_q <= '0;
      r_q        <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      stride_q   <= '0;
      num_rows_q <= '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        addr_q[k] <= '0;
      end
    end else begin
      row_base_q <= row_base_d;
      r_q        <= r_d;
      err_q      <= err_d;
      done_q     <= (state_q == ST_DONE);
      if (accept_start) begin
        stride_q   <= row_stride;
        num_rows_q <= num_rows;
      end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        addr_q[k] <= row_base_d + 32'(k);
      end
    end
  end

  assign ram_addr0 = addr_q[0];
  assign ram_addr1 = addr_q[1];
  assign ram_addr2 = addr_q[2];
  assign ram_addr3 = addr_q[3];
  assign err       = err_q;
  assign done      = done_q;

  rd_out_stage #(
    .WIDTH (OUT_W)
  ) u_out_stage (
    .clock      (clock),
    .reset      (reset),
    .load_i     (capture),
    .data_i     ({ram_q3, ram_q2, ram_q1, ram_q0}),
    .last_i     (last_row),
    .ready_i    (out_ready),
    .can_load_o (can_load),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .last_o     (out_last)
  );

endmodule
